// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, queue entry type and redirect causes for the fetch queue unit.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_DEF = 32'hBFC0_0380;
   localparam logic [31:0] KSEG1_LO = 32'hA000_0000;
   localparam logic [31:0] KSEG1_HI = 32'hBFFF_FFFF;
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            adel;
   } fq_entry_t;
   typedef enum logic [1:0] {RC_SEQ, RC_BR, RC_ERET, RC_EXC} redirect_e;
   function automatic logic is_uncached(input logic [31:0] pc);
      return pc >= KSEG1_LO && pc <= KSEG1_HI;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fq_entry_t with flush; head reads as zero when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  fq_entry_t     din_i,
   output fq_entry_t     dout_o,
   output logic [CW-1:0] count_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   fq_entry_t mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;
   logic full, do_push, do_pop;
   always_comb begin
      full = cnt_q == CW'(DEPTH);
      do_pop = pop_i && !flush_i && cnt_q != '0;
      do_push = push_i && !flush_i && (!full || do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q == LAST ? '0 : wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
   // Callers size their pushes by credit, so a push into a full FIFO is a design bug.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) assert (!(push_i && full && !do_pop));
   end
   assign dout_o = cnt_q != '0 ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: multi-outstanding fetch stage with a decoupling instruction queue and redirect squash.
// Defining FETCH_PERF_EN adds saturating perf counters for redirects, starvation and squashed words.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int MAX_OUT = 2,
   parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [WIDTH-1:0] EXC_VEC = EXC_VEC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   input  logic             br_req,
   input  logic [WIDTH-1:0] br_target,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   output logic             inst_uncached,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [WIDTH-1:0] inst_rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc,
   output logic             out_adel,
   output logic             fetch_busy
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      perf_redirects,
   output logic [31:0]      perf_starve,
   output logic [31:0]      perf_squashed
`endif
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(MAX_OUT + 1);
   logic [WIDTH-1:0] pc_q, pc_d, target;
   logic [CW-1:0] squash_q, squash_d, q_cnt;
   logic [PW-1:0] outst;
   logic adel_q, adel_d, redirect, issue, drop, q_push, q_pop, adel_push;
   redirect_e cause;
   fq_entry_t q_din, q_head, pcf_din, pcf_head, word_ent;
   always_comb begin
      cause = exc_req ? RC_EXC : eret_req ? RC_ERET : br_req ? RC_BR : RC_SEQ;
      redirect = cause != RC_SEQ;
      target = cause == RC_EXC ? EXC_VEC : cause == RC_ERET ? epc : br_target;
      // Credit check counts in-flight words against free queue slots so responses always fit.
      inst_req = !rst && !redirect && pc_q[1:0] == 2'b00 && outst < PW'(MAX_OUT)
                 && {1'b0, q_cnt} + (CW+1)'(outst) < (CW+1)'(DEPTH);
      issue = inst_req && inst_addr_ok;
      drop = inst_data_ok && (squash_q != '0 || redirect);
      adel_push = !redirect && pc_q[1:0] != 2'b00 && !adel_q && outst == '0 && q_cnt < CW'(DEPTH);
      q_push = (inst_data_ok && !drop) || adel_push;
      q_pop = out_valid && out_ready;
      squash_d = redirect ? CW'(outst) + CW'(issue) - CW'(inst_data_ok) : squash_q - CW'(drop);
      pc_d = redirect ? target : issue ? pc_q + WIDTH'(4) : pc_q;
      adel_d = !redirect && (adel_q || adel_push);
      word_ent = pcf_head;
      word_ent.instr = inst_rdata;
      q_din = adel_push ? '{instr: '0, pc: pc_q, adel: 1'b1} : word_ent;
      pcf_din = '{instr: '0, pc: pc_q, adel: 1'b0};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
         squash_q <= '0;
         adel_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         squash_q <= squash_d;
         adel_q <= adel_d;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_queue (
      .clk(clk), .rst(rst), .flush_i(redirect), .push_i(q_push), .pop_i(q_pop),
      .din_i(q_din), .dout_o(q_head), .count_o(q_cnt)
   );
   // Its occupancy is the outstanding-request count; squashed responses still pop it.
   fetch_fifo #(.DEPTH(MAX_OUT)) u_pcq (
      .clk(clk), .rst(rst), .flush_i(1'b0), .push_i(issue), .pop_i(inst_data_ok),
      .din_i(pcf_din), .dout_o(pcf_head), .count_o(outst)
   );
   assign inst_addr = {{(WIDTH-29){1'b0}}, pc_q[28:0]};
   assign inst_uncached = is_uncached(pc_q);
   assign out_valid = q_cnt != '0;
   assign out_instr = q_head.instr;
   assign out_pc = q_head.pc;
   assign out_adel = q_head.adel;
   assign fetch_busy = outst != '0 || squash_q != '0;
`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_redirects <= '0;
         perf_starve <= '0;
         perf_squashed <= '0;
      end else begin
         perf_redirects <= perf_redirects + 32'(redirect && perf_redirects != '1);
         perf_starve <= perf_starve + 32'(!out_valid && perf_starve != '1);
         perf_squashed <= perf_squashed + 32'(drop && perf_squashed != '1);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed and random checks of fetch_queue_unit against a transaction-level model.
module tb_fetch_queue_unit;
   import fetch_pkg::*;
   localparam int DEPTH = 4;
   localparam int MAX_OUT = 2;
   logic clk = 1'b0;
   logic rst = 1'b0, exc_req = 1'b0, eret_req = 1'b0, br_req = 1'b0;
   logic [31:0] epc = '0, br_target = '0, inst_addr, inst_rdata = '0, out_instr, out_pc;
   logic inst_req, inst_uncached, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
   logic out_valid, out_ready = 1'b0, out_adel, fetch_busy;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_redirects, perf_starve, perf_squashed;
   logic [31:0] m_red, m_starve, m_sq;
`endif
   always #5 clk = ~clk;
   fetch_queue_unit #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .br_req(br_req), .br_target(br_target), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_uncached(inst_uncached), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_adel(out_adel), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
      , .perf_redirects(perf_redirects), .perf_starve(perf_starve), .perf_squashed(perf_squashed)
`endif
   );
   typedef struct {logic [31:0] pc; bit stale;} fl_t;
   typedef struct {logic [31:0] instr; logic [31:0] pc; bit adel;} ent_t;
   fl_t infl[$];
   ent_t mq[$];
   logic [31:0] mpc;
   bit adel_sent, chk_en;
   int vectors = 0, miscompares = 0;
   function automatic logic [31:0] phys(input logic [31:0] a);
      return {3'b000, a[28:0]};
   endfunction
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_1E0F;
   endfunction
   function automatic logic [31:0] rnd_target();
      logic [31:0] t = $urandom;
      t[31:29] = $urandom_range(0, 1) ? 3'b100 : 3'b101;
      if ($urandom_range(0, 5) != 0) t[1:0] = 2'b00;
      return t;
   endfunction
   function automatic bit exp_req(input bit r, input bit redir);
      return !r && !redir && mpc[1:0] == 2'b00 && infl.size() < MAX_OUT && mq.size() + infl.size() < DEPTH;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
`ifdef FETCH_PERF_EN
   function automatic logic [31:0] sat(input logic [31:0] c, input bit en);
      return (en && c != '1) ? c + 1 : c;
   endfunction
`endif
   task automatic cyc(input bit r, input bit e, input bit er, input bit b, input logic [31:0] ep,
                      input logic [31:0] bt, input bit aok, input bit dreq, input bit rdy);
      bit dok, redir, rq, no_infl;
      int qn;
      logic [31:0] tgt;
      ent_t hd;
      fl_t f;
      @(negedge clk);
      dok = dreq && infl.size() != 0;
      rst = r; exc_req = e; eret_req = er; epc = ep; br_req = b; br_target = bt;
      inst_addr_ok = aok; inst_data_ok = dok; out_ready = rdy;
      inst_rdata = dok ? mem_word(phys(infl[0].pc)) : $urandom;
      redir = e || er || b;
      rq = exp_req(r, redir);
      #1;
      if (chk_en) begin
         if (mq.size() != 0) hd = mq[0];
         else hd = '{32'h0, 32'h0, 1'b0};
         chk("inst_req", 32'(inst_req), 32'(rq));
         chk("inst_addr", inst_addr, phys(mpc));
         chk("inst_uncached", 32'(inst_uncached), 32'(mpc >= 32'hA000_0000 && mpc <= 32'hBFFF_FFFF));
         chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         chk("out_pc", out_pc, hd.pc);
         chk("out_instr", out_instr, hd.instr);
         chk("out_adel", 32'(out_adel), 32'(hd.adel));
         chk("fetch_busy", 32'(fetch_busy), 32'(infl.size() != 0));
`ifdef FETCH_PERF_EN
         chk("perf_redirects", perf_redirects, m_red);
         chk("perf_starve", perf_starve, m_starve);
         chk("perf_squashed", perf_squashed, m_sq);
`endif
      end
      if (r) begin
         mpc = RESET_PC_DEF;
         mq.delete();
         infl.delete();
         adel_sent = 0;
`ifdef FETCH_PERF_EN
         m_red = 0; m_starve = 0; m_sq = 0;
`endif
      end else begin
         tgt = e ? EXC_VEC_DEF : er ? ep : bt;
         no_infl = infl.size() == 0;
         qn = mq.size();
`ifdef FETCH_PERF_EN
         m_red = sat(m_red, redir);
         m_starve = sat(m_starve, qn == 0);
         m_sq = sat(m_sq, dok && (infl[0].stale || redir));
`endif
         if (qn != 0 && rdy && !redir) void'(mq.pop_front());
         if (dok) begin
            f = infl.pop_front();
            if (!f.stale && !redir) mq.push_back('{mem_word(phys(f.pc)), f.pc, 1'b0});
         end
         if (rq && aok) begin
            infl.push_back('{mpc, 1'b0});
            mpc += 4;
         end else if (!redir && mpc[1:0] != 2'b00 && !adel_sent && no_infl && qn < DEPTH) begin
            mq.push_back('{32'h0, mpc, 1'b1});
            adel_sent = 1;
         end
         if (redir) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1;
            mpc = tgt;
            adel_sent = 0;
         end
      end
      @(posedge clk);
      #1;
      rst = 0; exc_req = 0; eret_req = 0; br_req = 0; inst_addr_ok = 0; inst_data_ok = 0;
   endtask
   initial begin
      chk_en = 0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_en = 1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_busy", 32'(fetch_busy), 0);
      chk("rst_req", 32'(inst_req), 1);
      chk("rst_addr", inst_addr, 32'h1FC0_0000);
      chk("rst_uncached", 32'(inst_uncached), 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1 chk("seq_addr", inst_addr, 32'h1FC0_0004);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1;
      chk("first_pc", out_pc, 32'hBFC0_0000);
      chk("first_instr", out_instr, mem_word(32'h1FC0_0000));
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1 chk("second_pc", out_pc, 32'hBFC0_0004);
      repeat (8) cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      repeat (10) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
      #1;
      chk("bp_req", 32'(inst_req), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_busy", 32'(fetch_busy), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1 chk("bp_resume", 32'(inst_req), 1);
      repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
      #1 chk("two_out_busy", 32'(fetch_busy), 1);
      cyc(0, 0, 0, 1, 0, 32'h8000_0100, 1, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      chk("sq_valid", 32'(out_valid), 0);
      chk("sq_busy", 32'(fetch_busy), 0);
      chk("br_addr", inst_addr, 32'h0000_0100);
      chk("br_uncached", 32'(inst_uncached), 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
      #1 chk("br_pc", out_pc, 32'h8000_0100);
      cyc(0, 1, 0, 1, 0, 32'h8000_0200, 1, 1, 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
      #1 chk("exc_pc", out_pc, 32'hBFC0_0380);
      cyc(0, 0, 1, 0, 32'h8000_0002, 0, 1, 1, 0);
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
      #1;
      chk("adel_valid", 32'(out_valid), 1);
      chk("adel_flag", 32'(out_adel), 1);
      chk("adel_pc", out_pc, 32'h8000_0002);
      chk("adel_instr", out_instr, 0);
      chk("adel_req", 32'(inst_req), 0);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      #1;
      chk("adel_once", 32'(out_valid), 0);
      chk("adel_hold", 32'(inst_req), 0);
      cyc(0, 0, 0, 1, 0, 32'hBFC0_1000, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
      #1 chk("mid_busy", 32'(fetch_busy), 1);
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
      #1;
      chk("mid_valid", 32'(out_valid), 0);
      chk("mid_busy_clr", 32'(fetch_busy), 0);
      chk("mid_addr", inst_addr, 32'h1FC0_0000);
      chk("mid_req", 32'(inst_req), 1);
      repeat (3000) begin
         cyc($urandom_range(0, 499) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 24) == 0, rnd_target(), rnd_target(),
             $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 6);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised fetch stage; successor of the single-PC IF stage.
- Keeps several instruction requests in flight on the inst SRAM-like bus (req / addr_ok / data_ok).
- Buffers returned words in a DEPTH-entry queue, decoupling fetch from decode through a valid/ready handshake.
- Handles redirects by flushing the queue and squashing in-flight responses; classifies kseg0 (cached) vs kseg1 (uncached) and flags misaligned PCs.

Parameters:
- WIDTH, 32, address/data width.
- DEPTH, 4, fetch-queue entries (power of two, ≥2).
- MAX_OUT, 2, max outstanding bus requests (1..DEPTH).
- RESET_PC, 32'hBFC0_0000, PC after reset.
- EXC_VEC, 32'hBFC0_0380, exception entry PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exc_req  in  1  exception redirect to EXC_VEC
- eret_req  in  1  redirect to epc
- epc  in  WIDTH  eret target
- br_req  in  1  branch/jump redirect
- br_target  in  WIDTH  branch/jump target
- inst_req  out  1  bus request valid
- inst_addr  out  WIDTH  physical address {3'b000, pc[28:0]}
- inst_uncached  out  1  request PC in 0xA000_0000..0xBFFF_FFFF
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  response valid (in order)
- inst_rdata  in  WIDTH  response word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  WIDTH  head instruction
- out_pc  out  WIDTH  head virtual PC
- out_adel  out  1  head is an address-error (PC[1:0]≠0) entry
- fetch_busy  out  1  outstanding≠0 or squash_cnt≠0

Behaviour:
- Decided: one clock clk; rst synchronous, active-high.
- Reset: pc=RESET_PC; queue empty; outstanding=0; squash_cnt=0; inst_req=0; out_valid=0; out_instr/out_pc=0; out_adel=0.
- Redirect priority: exc_req > eret_req > br_req > sequential (pc+4 on each addr_ok handshake). Redirects are single-cycle pulses.
- On a redirect cycle:
  - pc ← target; queue flushed.
  - squash_cnt ← outstanding + (inst_req & inst_addr_ok) − (data_ok counted toward squash).
  - outstanding is unaffected by the flush; it still tracks bus responses.
  - inst_req is forced 0 that cycle.
- Issue condition: inst_req=1 iff !redirect & pc[1:0]==0 & outstanding<MAX_OUT & (count+outstanding)<DEPTH. The credit check guarantees the queue never overflows.
- inst_req and inst_addr hold stable until addr_ok.
- Per cycle: outstanding += (inst_req&addr_ok) − data_ok.
- On data_ok:
  - squash_cnt≠0 → drop the word, squash_cnt−1.
  - Otherwise push {rdata, pc_of_request, adel=0}. Issued-PC FIFO of depth MAX_OUT carries pc_of_request.
- Misaligned pc with free queue slot and outstanding==0: push {instr=0, pc, adel=1} with no bus request, then hold pc until a redirect.
- Queue:
  - Head registered; out_valid = count≠0.
  - Pop on out_valid&out_ready; simultaneous push+pop keeps count.
  - Push into a full queue cannot occur; assert in sim.
  - Pointer wrap mod DEPTH.
- Latency: request accepted at cycle t, data_ok at t+k → out_valid at t+k+1 if queue was empty.
- Redirect and data_ok in the same cycle: the word is squashed (counted in squash_cnt computation). The queue pop is ignored.
- Redirect during squash: squash_cnt accumulates correctly; no stale word ever reaches the output.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_redirects[31:0] (count of redirect cycles), perf_starve[31:0] (cycles out_valid=0 & !rst), perf_squashed[31:0] (dropped words). All reset to 0 and saturate at max.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg: RESET_PC/EXC_VEC defaults, kseg bounds (KSEG1_LO=32'hA000_0000, KSEG1_HI=32'hBFFF_FFFF), typedef fq_entry_t {instr, pc, adel}, redirect-cause enum.
- Sub-module fetch_fifo: generic DEPTH×fq_entry_t synchronous FIFO with flush, count, push/pop. Instantiated twice: queue, and issued-PC FIFO with depth MAX_OUT.

Test Plan:
- Reset, bus returns data_ok one cycle after each addr_ok, out_ready=1 → addresses 0x1FC0_0000, 0x1FC0_0004…, inst_uncached=1, out_pc 0xBFC0_0000, +4 in order.
- out_ready=0, DEPTH=4, MAX_OUT=2 → at most 4 words enter the queue, then inst_req stays 0; releasing out_ready resumes issue.
- Two outstanding requests, br_req to 0x8000_0100 → both late words dropped (perf_squashed=2 if enabled); next out_pc=0x8000_0100, inst_uncached=0, inst_addr=0x0000_0100.
- exc_req and br_req in the same cycle → out_pc sequence restarts at 0xBFC0_0380.
- eret_req with epc=0x8000_0002 → single entry out_adel=1, out_pc=0x8000_0002, no inst_req issued.
- rst asserted mid-burst with 2 outstanding → next cycle out_valid=0, pc=RESET_PC, outstanding=0, inst_req follows issue rules.
